proc_bus_port: RTL
==================

Name: proc_bus_port

Overview:
- Processor-side requester for the shared snooping bus.
- Accepts cache-transfer requests from one cache controller into a small FIFO.
- Presents them to the bus one at a time as a single-cycle request pulse with a destination, then waits for that processor's completion bit.
- Returns a completion, with an error flag, to the cache; times out and retries on a lost completion.
- One instance per processor; the bus port vectors are the per-processor slices of the bus request/request_dest/request_avail arrays.

Parameters:
- NUM_PROC, 4, processors on the bus.
- PROC_ID, 0, index of this port's processor.
- DEPTH, 4, request FIFO entries (power of 2, >=2).
- ADDR_W, 64, address width.
- BRT_W, 3, bus request type width.
- TIMEOUT, 64, WAIT cycles before a reissue (>=2).
- MAX_RETRY, 3, reissues before an error completion.

Ports:
- clk  in  1  clock.
- rst_l  in  1  synchronous active-low reset.
- req_valid  in  1  cache request valid.
- req_ready  out  1  FIFO can accept.
- req_brt  in  BRT_W  request type.
- req_addr  in  ADDR_W  address.
- req_dest  in  $clog2(NUM_PROC)+1  destination processor.
- bus_request  out  1  one-cycle request pulse to the bus.
- bus_request_dest  out  $clog2(NUM_PROC)+1  destination for the pulse.
- bus_avail  in  1  this processor's request_avail bit.
- cmp_valid  out  1  one-cycle completion.
- cmp_brt  out  BRT_W  type of completed entry.
- cmp_addr  out  ADDR_W  address of completed entry.
- cmp_error  out  1  completion is an error (bad destination or retries exhausted).
- busy  out  1  state != IDLE or FIFO non-empty.

Behaviour:
- Interface: single clock clk; reset rst_l is synchronous and active-low.
- Reset (rst_l=0 at a clk edge):
  - FIFO emptied; state IDLE; timer=0; retry=0.
  - All outputs 0 except req_ready=1.
  - Applies identically mid-transaction. The in-flight entry is dropped, and no completion is emitted for it.
- FIFO:
  - Push when req_valid && req_ready.
  - req_ready = !full. Depends only on registered occupancy, so no same-cycle push-through when full.
  - Pop only in the DONE cycle.
  - Pointers wrap modulo DEPTH; count is $clog2(DEPTH)+1 bits.
  - A push and a pop in the same cycle leave the count unchanged.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - FIFO non-empty and head dest < NUM_PROC and head dest != PROC_ID → ISSUE.
  - Head dest invalid (dest == PROC_ID or dest >= NUM_PROC) → DONE with error latched; nothing is driven on the bus.
- ISSUE (exactly one cycle):
  - bus_request=1, bus_request_dest=head dest.
  - Timer cleared. Next state is WAIT.
- WAIT:
  - bus_request=0.
  - bus_avail=1 → DONE, error=0.
  - Otherwise the timer increments. When timer==TIMEOUT-1:
    - retry<MAX_RETRY → retry++, go to ISSUE.
    - Else → DONE, error=1.
  - bus_avail has priority over timeout in the same cycle.
- DONE (one cycle):
  - cmp_valid=1; cmp_brt/cmp_addr come from the FIFO head; cmp_error=latched error.
  - Pop; clear retry; go to IDLE.
- bus_avail outside WAIT (including the ISSUE cycle) is ignored.
- bus_request_dest is 0 whenever bus_request=0.
- Latency:
  - Push at cycle N → ISSUE at N+2 at the earliest.
  - bus_avail sampled in WAIT at cycle M → cmp_valid at M+1.
  - Back-to-back entries: next ISSUE two cycles after DONE.
- Reissue count equals the number of bus_request pulses minus 1, and is at most MAX_RETRY.

Decomposition:
- Package bus_pkg holds:
  - typedef proc_dest_t ($clog2(NUM_PROC)+1 bits).
  - typedef bus_req_t (brt, addr, dest).
  - enum port_state_t {IDLE, ISSUE, WAIT, DONE}.
  - The BRT encodings shared with the bus model.
- One sub-module: req_fifo (parameterized DEPTH, payload bus_req_t, push/pop/full/empty), reused later by the bus arbiter queues.

Test Plan:
- Reset/idle: assert rst_l=0 for 2 cycles, release → req_ready=1; bus_request=0, cmp_valid=0, busy=0.
- Single request:
  - Stimulus: PROC_ID=0; push {brt=2, addr=0x1000, dest=2} at cycle 10; bus_avail=1 at cycle 14.
  - Response: bus_request=1 with dest=2 only at cycle 12; cmp_valid=1 at cycle 15 with addr=0x1000, brt=2, error=0.
- FIFO full/order:
  - Stimulus: push 5 requests back-to-back with no bus_avail.
  - Response: req_ready drops after the 4th push; the 5th is held. Completions come in push order once avail is supplied per issue.
- Timeout/retry:
  - Stimulus: TIMEOUT=8, MAX_RETRY=2, never assert bus_avail.
  - Response: 3 bus_request pulses 9 cycles apart, then cmp_valid with cmp_error=1.
- Bad destination: push dest=PROC_ID, then dest=4 → no bus_request; two error completions, 2 cycles after each reaches the head.
- Edge cases:
  - bus_avail coinciding with the timeout cycle → error=0 and no reissue.
  - bus_avail during ISSUE only → ignored.
  - rst_l=0 during WAIT → no completion; FIFO empty after reset.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the snooping-bus slice: request payload, port FSM states
// and the bus request-type encodings understood by the bus model.
package bus_pkg;

    localparam int BUS_NUM_PROC = 4;
    localparam int BUS_DEST_W   = $clog2(BUS_NUM_PROC) + 1;
    localparam int BUS_ADDR_W   = 64;
    localparam int BUS_BRT_W    = 3;

    typedef logic [BUS_DEST_W-1:0] proc_dest_t;

    typedef struct packed {
        logic [BUS_BRT_W-1:0]  brt;
        logic [BUS_ADDR_W-1:0] addr;
        proc_dest_t            dest;
    } bus_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } port_state_t;

    localparam logic [BUS_BRT_W-1:0] BRT_NONE      = 3'd0;
    localparam logic [BUS_BRT_W-1:0] BRT_READ      = 3'd1;
    localparam logic [BUS_BRT_W-1:0] BRT_READX     = 3'd2;
    localparam logic [BUS_BRT_W-1:0] BRT_UPGRADE   = 3'd3;
    localparam logic [BUS_BRT_W-1:0] BRT_WRITEBACK = 3'd4;

endpackage

// File: rtl/proc_bus_port_if.sv
// Cache-request, bus and completion signals of one processor's bus port.
// master is the port itself; slave is the cache/bus side driving it.
interface proc_bus_port_if #(
    parameter int ADDR_W = 64,
    parameter int BRT_W  = 3,
    parameter int DEST_W = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [BRT_W-1:0]  req_brt;
    logic [ADDR_W-1:0] req_addr;
    logic [DEST_W-1:0] req_dest;
    logic              bus_request;
    logic [DEST_W-1:0] bus_request_dest;
    logic              bus_avail;
    logic              cmp_valid;
    logic [BRT_W-1:0]  cmp_brt;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_error;

    modport master (
        input  req_valid, req_brt, req_addr, req_dest, bus_avail,
        output req_ready, bus_request, bus_request_dest,
               cmp_valid, cmp_brt, cmp_addr, cmp_error
    );

    modport slave (
        output req_valid, req_brt, req_addr, req_dest, bus_avail,
        input  req_ready, bus_request, bus_request_dest,
               cmp_valid, cmp_brt, cmp_addr, cmp_error
    );

endinterface

// File: rtl/req_fifo.sv
// Small synchronous request FIFO with registered occupancy; the head entry is
// visible combinationally so the consumer can inspect it before popping.
module req_fifo
    import bus_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = bus_req_t
) (
    input  logic clk,
    input  logic rst_l,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output T     head,
    output logic full,
    output logic empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign head      = mem_r[rd_ptr_r];

    // Payload storage; contents are meaningless until counted as occupied.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally at DEPTH; push+pop together hold the count.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/proc_bus_port.sv
// Processor-side bus requester: queues cache transfers, pulses them onto the
// bus one at a time, waits for completion with timeout/retry, reports back.
module proc_bus_port
    import bus_pkg::*;
#(
    parameter int NUM_PROC  = 4,
    parameter int PROC_ID   = 0,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 64,
    parameter int BRT_W     = 3,
    parameter int TIMEOUT   = 64,
    parameter int MAX_RETRY = 3
) (
    input  logic            clk,
    input  logic            rst_l,
    proc_bus_port_if.master bif,
    output logic            busy
);

    localparam int DEST_W = $clog2(NUM_PROC) + 1;
    localparam int TMR_W  = $clog2(TIMEOUT) + 1;
    localparam int RTY_W  = $clog2(MAX_RETRY + 1) + 1;

    typedef struct packed {
        logic [BRT_W-1:0]  brt;
        logic [ADDR_W-1:0] addr;
        logic [DEST_W-1:0] dest;
    } req_t;

    req_t              push_data_s;
    req_t              head_s;
    logic              full_s;
    logic              empty_s;
    logic              pop_s;

    port_state_t       state_r;
    logic [TMR_W-1:0]  timer_r;
    logic [RTY_W-1:0]  retry_r;
    logic              bus_request_r;
    logic [DEST_W-1:0] bus_request_dest_r;
    logic              cmp_valid_r;
    logic [BRT_W-1:0]  cmp_brt_r;
    logic [ADDR_W-1:0] cmp_addr_r;
    logic              cmp_error_r;

    // A request to ourselves or to a nonexistent processor can never complete.
    function automatic logic dest_ok(input logic [DEST_W-1:0] d);
        return (d < DEST_W'(NUM_PROC)) && (d != DEST_W'(PROC_ID));
    endfunction

    // Pack the incoming cache request into the FIFO payload.
    always_comb begin
        push_data_s      = '0;
        push_data_s.brt  = bif.req_brt;
        push_data_s.addr = bif.req_addr;
        push_data_s.dest = bif.req_dest;
    end

    assign pop_s = (state_r == DONE);

    req_fifo #(
        .DEPTH (DEPTH),
        .T     (req_t)
    ) u_fifo (
        .clk       (clk),
        .rst_l     (rst_l),
        .push      (bif.req_valid),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign bif.req_ready        = !full_s;
    assign bif.bus_request      = bus_request_r;
    assign bif.bus_request_dest = bus_request_dest_r;
    assign bif.cmp_valid        = cmp_valid_r;
    assign bif.cmp_brt          = cmp_brt_r;
    assign bif.cmp_addr         = cmp_addr_r;
    assign bif.cmp_error        = cmp_error_r;
    assign busy                 = (state_r != IDLE) || !empty_s;

    // Port FSM; pulse and completion outputs are loaded on entry to ISSUE/DONE
    // and fall back to zero the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_r            <= IDLE;
            timer_r            <= {TMR_W{1'b0}};
            retry_r            <= {RTY_W{1'b0}};
            bus_request_r      <= 1'b0;
            bus_request_dest_r <= {DEST_W{1'b0}};
            cmp_valid_r        <= 1'b0;
            cmp_brt_r          <= {BRT_W{1'b0}};
            cmp_addr_r         <= {ADDR_W{1'b0}};
            cmp_error_r        <= 1'b0;
        end else begin
            bus_request_r      <= 1'b0;
            bus_request_dest_r <= {DEST_W{1'b0}};
            cmp_valid_r        <= 1'b0;
            cmp_brt_r          <= {BRT_W{1'b0}};
            cmp_addr_r         <= {ADDR_W{1'b0}};
            cmp_error_r        <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (!empty_s && dest_ok(head_s.dest)) begin
                        state_r            <= ISSUE;
                        bus_request_r      <= 1'b1;
                        bus_request_dest_r <= head_s.dest;
                    end else if (!empty_s) begin
                        state_r     <= DONE;
                        cmp_valid_r <= 1'b1;
                        cmp_brt_r   <= head_s.brt;
                        cmp_addr_r  <= head_s.addr;
                        cmp_error_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    timer_r <= {TMR_W{1'b0}};
                    state_r <= WAIT;
                end
                WAIT: begin
                    if (bif.bus_avail) begin
                        state_r     <= DONE;
                        cmp_valid_r <= 1'b1;
                        cmp_brt_r   <= head_s.brt;
                        cmp_addr_r  <= head_s.addr;
                        cmp_error_r <= 1'b0;
                    end else if (timer_r == TMR_W'(TIMEOUT - 1) &&
                                 retry_r < RTY_W'(MAX_RETRY)) begin
                        retry_r            <= retry_r + 1'b1;
                        state_r            <= ISSUE;
                        bus_request_r      <= 1'b1;
                        bus_request_dest_r <= head_s.dest;
                    end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
                        state_r     <= DONE;
                        cmp_valid_r <= 1'b1;
                        cmp_brt_r   <= head_s.brt;
                        cmp_addr_r  <= head_s.addr;
                        cmp_error_r <= 1'b1;
                    end else begin
                        timer_r <= timer_r + 1'b1;
                    end
                end
                DONE: begin
                    retry_r <= {RTY_W{1'b0}};
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
